// File: rtl/ssd1306_frame_tx_if.sv
// Control, framebuffer-read and display-write signals of ssd1306_frame_tx.
// master is the transmitter side, slave is the framebuffer/host/display side.
interface ssd1306_frame_tx_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       fb_rd;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       wclk;
    logic       cs;
    logic       write_en;
    logic [1:0] din;

    modport master (
        input  start, fb_data,
        output busy, done, fb_rd, fb_addr, wclk, cs, write_en, din
    );

    modport slave (
        output start, fb_data,
        input  busy, done, fb_rd, fb_addr, wclk, cs, write_en, din
    );
endinterface

// File: rtl/ssd1306_frame_tx.sv
// Streams a 128x64 framebuffer to an SSD1306-style serial pixel port, one wclk pulse per pixel.
// Define SSD1306_FRAME_TX_AUTO_EN to send frames back-to-back without a start request.
module ssd1306_frame_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               CLK25MHz,
    input  logic               reset_n,
    ssd1306_frame_tx_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        FETCH,
        SHIFT,
        FINISH
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic       high_q, high_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    logic       fetch2_q, fetch2_d;
    logic [7:0] shreg_q, shreg_d;

    logic       wclk_q, wclk_d;
    logic       cs_q, cs_d;
    logic       write_en_q, write_en_d;
    logic       din_q, din_d;
    logic       fb_rd_q, fb_rd_d;
    logic [9:0] fb_addr_q, fb_addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       half_end;
    logic       pulse_end;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        high_d    = high_q;
        bit_d     = bit_q;
        page_d    = page_q;
        col_d     = col_q;
        fetch2_d  = fetch2_q;
        shreg_d   = shreg_q;
        half_end  = (phase_q == DIV_LAST);
        pulse_end = half_end && high_q;

        case (state_q)
            IDLE: begin
`ifdef SSD1306_FRAME_TX_AUTO_EN
                state_d = SYNC;
`else
                if (bus.start) begin
                    state_d = SYNC;
                end
`endif
            end

            SYNC, SHIFT: begin
                phase_d = half_end ? 8'd0 : phase_q + 8'd1;
                if (half_end) begin
                    high_d = ~high_q;
                end
                if (pulse_end) begin
                    if (state_q == SYNC) begin
                        state_d = FETCH;
                    end else if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end else begin
                        // Page runs fastest; both counters wrap to 0 after the final byte.
                        bit_d  = 3'd0;
                        page_d = page_q + 3'd1;
                        if (page_q == 3'd7) begin
                            col_d = col_q + 7'd1;
                        end
                        state_d = (page_q == 3'd7 && col_q == 7'd127) ? FINISH : FETCH;
                    end
                end
            end

            FETCH: begin
                fetch2_d = ~fetch2_q;
                if (fetch2_q) begin
                    shreg_d = bus.fb_data;
                    state_d = SHIFT;
                end
            end

            FINISH: begin
`ifdef SSD1306_FRAME_TX_AUTO_EN
                state_d = SYNC;
`else
                state_d = IDLE;
`endif
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
        cs_d       = (state_d == IDLE);
        write_en_d = (state_d == FETCH) || (state_d == SHIFT) || (state_d == FINISH);
        wclk_d     = ((state_d == SYNC) || (state_d == SHIFT)) && high_d;
        fb_rd_d    = (state_d == FETCH) && !fetch2_d;
        fb_addr_d  = fb_rd_d ? {page_d, col_d} : fb_addr_q;

        if (state_d == SHIFT) begin
            din_d = shreg_d[7];
        end else if (state_d == FETCH) begin
            din_d = din_q;
        end else begin
            din_d = 1'b0;
        end
    end

    always_ff @(posedge CLK25MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            phase_q    <= 8'd0;
            high_q     <= 1'b0;
            bit_q      <= 3'd0;
            page_q     <= 3'd0;
            col_q      <= 7'd0;
            fetch2_q   <= 1'b0;
            shreg_q    <= 8'd0;
            wclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            write_en_q <= 1'b0;
            din_q      <= 1'b0;
            fb_rd_q    <= 1'b0;
            fb_addr_q  <= 10'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
            state_q    <= state_d;
            phase_q    <= phase_d;
            high_q     <= high_d;
            bit_q      <= bit_d;
            page_q     <= page_d;
            col_q      <= col_d;
            fetch2_q   <= fetch2_d;
            shreg_q    <= shreg_d;
            wclk_q     <= wclk_d;
            cs_q       <= cs_d;
            write_en_q <= write_en_d;
            din_q      <= din_d;
            fb_rd_q    <= fb_rd_d;
            fb_addr_q  <= fb_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fb_rd    = fb_rd_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.wclk     = wclk_q;
    assign bus.cs       = cs_q;
    assign bus.write_en = write_en_q;
    assign bus.din      = {1'b0, din_q};
endmodule

// File: doc/ssd1306_frame_tx.md
SSD1306_FRAME_TX -- requirements
Module: ssd1306_frame_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, meaning CLK25MHz cycles per wclk half-period (legal range 1..255).
REQ-002 SHALL provide port CLK25MHz, input, 1 bit: sole clock; all logic is rising-edge.
REQ-003 SHALL provide port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: one-cycle request to send one frame.
REQ-005 SHALL provide port busy, output, 1 bit: high from the cycle after an accepted start through the FINISH cycle.
REQ-006 SHALL provide port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-007 SHALL provide port fb_rd, output, 1 bit: framebuffer read strobe.
REQ-008 SHALL provide port fb_addr, output, 10 bits: framebuffer byte address, page*128+col.
REQ-009 SHALL provide port fb_data, input, 8 bits: byte, valid the cycle after fb_rd; bit0 is the top row of the page.
REQ-010 SHALL provide port wclk, output, 1 bit: write clock; the display samples on its rising edge.
REQ-011 SHALL provide port cs, output, 1 bit: chip select, active low.
REQ-012 SHALL provide port write_en, output, 1 bit: DC; 0 with cs low is an address reset, 1 is pixel data.
REQ-013 SHALL provide port din, output, 2 bits: din[0] is the pixel and din[1] is tied to 0.

Function
REQ-014 SHALL implement states IDLE, SYNC, FETCH, SHIFT and FINISH.
REQ-015 In IDLE, start=1 SHALL move the FSM to SYNC on the next cycle; start SHALL be ignored in every other state.
REQ-016 SYNC SHALL last 2*CLK_DIV cycles with cs=0, write_en=0 and din=0, and wclk low for the first CLK_DIV cycles and high for the rest (one address-reset pulse).
REQ-017 FETCH SHALL last 2 cycles: cycle 1 drives fb_rd=1 and fb_addr; cycle 2 latches fb_data into an 8-bit shift register.
REQ-018 SHIFT SHALL emit 8 wclk pulses per byte, each CLK_DIV cycles low then CLK_DIV cycles high, with cs=0 and write_en=1.
REQ-019 Bits SHALL be sent MSB first (bit7 first); din SHALL be stable for the whole pulse and change only at the start of the low phase.
REQ-020 Byte order SHALL be col outer 0..127 and page inner 0..7, giving display address col*64+page*8+(7-bit); the first fb_addr is 0, the second 128, and the last 1023.
REQ-021 Between bytes, wclk SHALL stay low and cs SHALL stay low.
REQ-022 After the byte at fb_addr=1023 completes SHIFT, FINISH SHALL last 1 cycle with done=1, then cs=1 and the FSM returns to IDLE.
REQ-023 A frame SHALL consist of exactly 1 write_en=0 pulse followed by 8192 write_en=1 pulses.
REQ-024 Busy length SHALL be 2*CLK_DIV + 1024*(2+16*CLK_DIV) + 1 cycles; this is 34821 cycles at CLK_DIV=2.
REQ-025 Col and page counters SHALL wrap to 0 at frame end, and the bit counter SHALL wrap per byte without overflow.
REQ-026 fb_rd SHALL be 0 and fb_addr SHALL hold its last value outside FETCH cycle 1.

Reset
REQ-027 While reset_n=0, outputs SHALL be: wclk=0, cs=1, write_en=0, din=0, fb_rd=0, fb_addr=0, busy=0, done=0; all counters SHALL be 0 and the FSM SHALL be in IDLE.
REQ-028 Reset asserted mid-frame SHALL force cs=1 and wclk=0 immediately without completing the current pulse, and SHALL produce no done pulse.
REQ-029 After reset_n deasserts, no frame SHALL start until a new start is accepted (or the auto-restart condition of REQ-030 applies).

Configuration
REQ-030 With macro SSD1306_FRAME_TX_AUTO_EN defined, FINISH SHALL go directly to SYNC, sending frames back-to-back; busy SHALL stay 1, done SHALL still pulse once per frame, start SHALL be ignored, and the first frame SHALL begin 1 cycle after reset deasserts.
REQ-031 Without SSD1306_FRAME_TX_AUTO_EN, frames SHALL be sent only on an accepted start, as in REQ-015.

Verification (CLK_DIV=2)
REQ-032 Bench SHALL drive a start pulse with fb holding the pattern data=addr[7:0], and SHALL require 1 write_en=0 pulse, 8192 data pulses, the fb_addr sequence 0,128,...,896,1,129,...,1023, and done 34821 cycles after busy rises.
REQ-033 Bench SHALL set byte 0 to 0x01 and all other bytes to 0, and SHALL require that the 8th data pulse has din[0]=1 and every other pulse has din[0]=0.
REQ-034 Bench SHALL pulse start again at cycle 1000 of a frame, and SHALL require no change to the frame and no extra SYNC pulse.
REQ-035 Bench SHALL assert reset_n=0 during data pulse 4000, and SHALL require cs=1 and wclk=0 within the same cycle, no done pulse, and a full 8192-pulse frame on the next start.
REQ-036 Bench SHALL count rising edges of wclk where cs=0, and SHALL require 8193 per frame, with din and write_en stable within ±0 cycles of each edge.
REQ-037 With SSD1306_FRAME_TX_AUTO_EN defined and no start, bench SHALL require done pulses every 34821 cycles and a SYNC pulse beginning the cycle after each done.
